// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences PC increment/load/hold commands, buffers redirects
// that arrive while downstream is stalled, and halts on misaligned targets.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic [1:0]  PC_op,
    output logic [31:0] PC_in,
    output logic        fetch_valid,
    output logic        flush,
    output logic        redir_pending,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STALL  = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b10;

    state_t      state;
    logic [31:0] redir_buf;
    logic        active;
    logic        bad_redir;
    logic        defer;

    assign active    = (state == RUN) || (state == STALL) || (state == FLUSH);
    assign bad_redir = redir_valid && (redir_target[1:0] != 2'b00);
    // A redirect cannot be loaded while stalled or during the flush bubble, so it is parked
    assign defer     = stall || (state == FLUSH);

    always_comb begin
        PC_op = OP_HOLD;
        PC_in = '0;
        if (active && !bad_redir) begin
            if (redir_valid) begin
                if (!defer) begin
                    PC_op = OP_LOAD;
                    PC_in = redir_target;
                end else if (!stall) begin
                    PC_op = OP_INC;
                end
            end else if (!halt_req && !stall) begin
                if (redir_pending) begin
                    PC_op = OP_LOAD;
                    PC_in = redir_buf;
                end else begin
                    PC_op = OP_INC;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            redir_buf     <= '0;
            fetch_valid   <= 1'b0;
            flush         <= 1'b0;
            redir_pending <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                    if (en) state <= RUN;
                end
                RUN, STALL, FLUSH: begin
                    flush <= 1'b0;
                    if (bad_redir) begin
                        misalign_err  <= 1'b1;
                        fetch_valid   <= 1'b0;
                        redir_pending <= 1'b0;
                        redir_buf     <= '0;
                        state         <= HALTED;
                    end else if (redir_valid) begin
                        if (defer) begin
                            redir_buf     <= redir_target;
                            redir_pending <= 1'b1;
                            if (stall) begin
                                state <= STALL;
                            end else begin
                                fetch_valid <= 1'b1;
                                state       <= RUN;
                            end
                        end else begin
                            redir_pending <= 1'b0;
                            fetch_valid   <= 1'b0;
                            flush         <= 1'b1;
                            state         <= FLUSH;
                        end
                    end else if (halt_req) begin
                        fetch_valid   <= 1'b0;
                        redir_pending <= 1'b0;
                        redir_buf     <= '0;
                        state         <= HALTED;
                    end else if (stall) begin
                        state <= STALL;
                    end else if (redir_pending) begin
                        redir_pending <= 1'b0;
                        fetch_valid   <= 1'b0;
                        flush         <= 1'b1;
                        state         <= FLUSH;
                    end else begin
                        fetch_valid <= 1'b1;
                        state       <= RUN;
                    end
                end
                HALTED: begin
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                end
                default: begin
                    fetch_valid   <= 1'b0;
                    flush         <= 1'b0;
                    redir_pending <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 en  input  1  start fetching; sampled only in IDLE.
REQ-004 stall  input  1  downstream cannot accept; freeze PC.
REQ-005 halt_req  input  1  stop fetching permanently until reset.
REQ-006 redir_valid  input  1  branch/jump redirect request, one-cycle pulse per request.
REQ-007 redir_target  input  32  redirect byte address, qualified by redir_valid.
REQ-008 PC_op  output  2  PC command: 00 increment, 01 load, 10 hold; 11 never driven.
REQ-009 PC_in  output  32  load address, meaningful only when PC_op=01, else 0.
REQ-010 fetch_valid  output  1  registered; instruction at PC output is valid for decode.
REQ-011 flush  output  1  registered; one-cycle pulse, kill younger instruction in decode.
REQ-012 redir_pending  output  1  registered; buffered redirect awaiting stall release.
REQ-013 misalign_err  output  1  registered, sticky; misaligned redirect seen.

Function
REQ-014 States IDLE, RUN, STALL, FLUSH, HALTED; 3-bit state register, unused encodings return to IDLE next edge.
REQ-015 PC_op and PC_in are combinational from current state, inputs and redirect buffer; all other outputs are registered.
REQ-016 IDLE: PC_op=10, fetch_valid=0; en=1 -> RUN next edge.
REQ-017 Event priority in RUN/STALL, highest first: misaligned redirect, valid redirect, halt_req, stall.
REQ-018 RUN, no events: PC_op=00, fetch_valid=1 next edge; stays RUN.
REQ-019 RUN, redir_valid=1, redir_target[1:0]=00, stall=0: PC_op=01, PC_in=redir_target same cycle; next edge -> FLUSH.
REQ-020 FLUSH lasts exactly one cycle: flush=1, fetch_valid=0, PC_op=00; then RUN (or STALL if stall=1, PC_op=10 that cycle).
REQ-021 RUN, stall=1, no redirect: PC_op=10; next edge -> STALL, fetch_valid holds previous value.
REQ-022 STALL: PC_op=10 while stall=1; redir_valid in STALL or coincident with stall stores target in buffer, redir_pending=1 next edge.
REQ-023 Newer redirect while redir_pending=1 overwrites buffered target; only the latest is applied.
REQ-024 STALL, stall=0, redir_pending=1: PC_op=01, PC_in=buffered target; redir_pending clears, next edge -> FLUSH.
REQ-025 STALL, stall=0, redir_pending=0, redir_valid=1: treated as REQ-019; otherwise PC_op=00, -> RUN.
REQ-026 Redirect with redir_target[1:0]!=00 in RUN/STALL: not loaded, PC_op=10, misalign_err=1 and -> HALTED next edge.
REQ-027 halt_req=1 in RUN/STALL/FLUSH (no redirect): PC_op=10, -> HALTED; buffered redirect discarded.
REQ-028 HALTED: PC_op=10, fetch_valid=0, flush=0; all inputs ignored; exit only by reset.
REQ-029 redir_valid, halt_req and en ignored in IDLE.

Reset
REQ-030 rst=0 immediately forces state=IDLE, PC_op=10, PC_in=0, fetch_valid=0, flush=0, redir_pending=0, misalign_err=0, buffer=0, independent of clk.
REQ-031 Reset mid-operation (any state, pending redirect) discards all state; first edge after rst=1 evaluates IDLE.

Verification
REQ-032 Reset, en=1 for one cycle, run 3 cycles -> PC_op=00 each RUN cycle, fetch_valid=1 from first RUN edge onward.
REQ-033 RUN, redir_valid=1, target=0x0000_0014 -> PC_op=01, PC_in=0x14 same cycle; flush=1 and fetch_valid=0 next cycle; PC_op=00 after.
REQ-034 stall=1 for 3 cycles with redir_valid pulses to 0x20 then 0x40 -> PC_op=10 throughout, redir_pending=1; on stall=0, PC_op=01, PC_in=0x40, then flush pulse.
REQ-035 RUN, redir_valid=1, target=0x0000_00FE -> PC_op=10, misalign_err=1, HALTED; later en/redir ignored, PC_op stays 10.
REQ-036 halt_req=1 and stall=1 same cycle -> HALTED; assert rst=0 mid-cycle -> all outputs at reset values before next edge.
REQ-037 Simultaneous redir_valid (aligned) and halt_req in RUN -> redirect wins (PC_op=01, FLUSH); halt_req must be reasserted to halt.
